// File: rtl/id_regfile_sb.sv
// Decode-stage register file: two combinational read ports with write-through,
// plus a per-register pending-writer scoreboard that raises a RAW stall.
module id_regfile_sb #(
    parameter int NREG = 32,
    parameter int CNTW = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] WB_Data,
    input  logic        WB_Write,
    input  logic [4:0]  WB_Addr,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    input  logic        rs_use,
    input  logic        rt_use,
    input  logic        iss_valid,
    input  logic        iss_we,
    input  logic [4:0]  iss_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic        stall,
    output logic        err_ovf,
    output logic        err_unf
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [31:0]     regs [NREG];
    logic [CNTW-1:0] cnt  [NREG];

    logic [NREG-1:0] inc_v, dec_v, sat_v, zero_v;
    logic            ovf_hit, unf_hit;
    logic            rs_dec, rt_dec, rs_pend, rt_pend;

    // Issue handshake: iss_valid is a one-cycle pulse from ID meaning "this
    // instruction leaves ID now"; ID must drop it while stall is high. The
    // block never gates it, so a stalled issue is still counted if presented.
    always_comb begin
        inc_v  = '0;
        dec_v  = '0;
        sat_v  = '0;
        zero_v = '0;
        if (iss_valid && iss_we) inc_v[iss_addr] = 1'b1;
        if (WB_Write)            dec_v[WB_Addr]  = 1'b1;
        inc_v[0] = 1'b0;
        dec_v[0] = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            sat_v[r]  = (cnt[r] == CNT_MAX);
            zero_v[r] = (cnt[r] == '0);
        end
        ovf_hit = |(inc_v & ~dec_v & sat_v);
        unf_hit = |(dec_v & ~inc_v & zero_v);
    end

    // The writer retiring this cycle is covered by write-through, so it does
    // not count toward the stall.
    always_comb begin
        rs_dec  = WB_Write && (WB_Addr == rs_addr);
        rt_dec  = WB_Write && (WB_Addr == rt_addr);
        rs_pend = (cnt[rs_addr] > 1) || ((cnt[rs_addr] == 1) && !rs_dec);
        rt_pend = (cnt[rt_addr] > 1) || ((cnt[rt_addr] == 1) && !rt_dec);
        stall   = (rs_use && (rs_addr != '0) && rs_pend) ||
                  (rt_use && (rt_addr != '0) && rt_pend);
    end

    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (rs_addr != '0) rs_data = rs_dec ? WB_Data : regs[rs_addr];
        if (rt_addr != '0) rt_data = rt_dec ? WB_Data : regs[rt_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            if (WB_Write && (WB_Addr != '0)) regs[WB_Addr] <= WB_Data;
            for (int r = 1; r < NREG; r++) begin
                case ({inc_v[r], dec_v[r]})
                    2'b10:   if (!sat_v[r])  cnt[r] <= cnt[r] + 1'b1;
                    2'b01:   if (!zero_v[r]) cnt[r] <= cnt[r] - 1'b1;
                    default: cnt[r] <= cnt[r];
                endcase
            end
            if (ovf_hit) err_ovf <= 1'b1;
            if (unf_hit) err_unf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_id_regfile_sb.sv
// Scoreboard bench for id_regfile_sb: directed scenarios then randomized traffic
// against a behavioural model of registers and pending-writer counts.
module tb_id_regfile_sb;

    localparam int W = 32 + 32 + 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] WB_Data;
    logic        WB_Write;
    logic [4:0]  WB_Addr;
    logic [4:0]  rs_addr, rt_addr;
    logic        rs_use, rt_use;
    logic        iss_valid, iss_we;
    logic [4:0]  iss_addr;
    logic [31:0] rs_data, rt_data;
    logic        stall, err_ovf, err_unf;

    id_regfile_sb dut (
        .clk(clk), .rst(rst),
        .WB_Data(WB_Data), .WB_Write(WB_Write), .WB_Addr(WB_Addr),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_use(rs_use), .rt_use(rt_use),
        .iss_valid(iss_valid), .iss_we(iss_we), .iss_addr(iss_addr),
        .rs_data(rs_data), .rt_data(rt_data),
        .stall(stall), .err_ovf(err_ovf), .err_unf(err_unf)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_mem [32];
    int          m_pend [32];
    logic        m_ovf, m_unf;

    logic [W-1:0] exp_q [$];
    int  checks = 0;
    int  errors = 0;
    logic done = 1'b0;

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 0;
        end
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (WB_Write && WB_Addr == a) return WB_Data;
        return m_mem[a];
    endfunction

    function automatic logic m_busy(input logic [4:0] a);
        int p;
        p = m_pend[a];
        if (WB_Write && WB_Addr == a && p > 0) p = p - 1;
        return (a != 0) && (p != 0);
    endfunction

    task automatic model_edge();
        if (rst) begin
            model_clear();
        end else begin
            if (WB_Write && WB_Addr != 0) m_mem[WB_Addr] = WB_Data;
            if (iss_valid && iss_we && iss_addr != 0 &&
                !(WB_Write && WB_Addr == iss_addr)) begin
                if (m_pend[iss_addr] == 3) m_ovf = 1'b1;
                else m_pend[iss_addr] = m_pend[iss_addr] + 1;
            end
            if (WB_Write && WB_Addr != 0 &&
                !(iss_valid && iss_we && iss_addr == WB_Addr)) begin
                if (m_pend[WB_Addr] == 0) m_unf = 1'b1;
                else m_pend[WB_Addr] = m_pend[WB_Addr] - 1;
            end
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs, then advance.
    task automatic cyc(input logic r, input logic wbw, input logic [4:0] wba,
                       input logic [31:0] wbd, input logic [4:0] rsa,
                       input logic [4:0] rta, input logic rsu, input logic rtu,
                       input logic iv, input logic iwe, input logic [4:0] ia);
        logic stall_e;
        rst = r; WB_Write = wbw; WB_Addr = wba; WB_Data = wbd;
        rs_addr = rsa; rt_addr = rta; rs_use = rsu; rt_use = rtu;
        iss_valid = iv; iss_we = iwe; iss_addr = ia;
        stall_e = (rsu && m_busy(rsa)) || (rtu && m_busy(rta));
        exp_q.push_back({m_read(rsa), m_read(rta), stall_e, m_ovf, m_unf});
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input logic [4:0] rsa, input logic [4:0] rta);
        cyc(0, 0, 0, 0, rsa, rta, 1, 1, 0, 0, 0);
    endtask

    // Monitor: compares DUT outputs against the queued expectation mid-cycle.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks += 5;
            if (rs_data !== e[66:35]) begin
                errors++;
                $display("FAIL rs_data t=%0t got=%h exp=%h", $time, rs_data, e[66:35]);
            end
            if (rt_data !== e[34:3]) begin
                errors++;
                $display("FAIL rt_data t=%0t got=%h exp=%h", $time, rt_data, e[34:3]);
            end
            if (stall !== e[2]) begin
                errors++;
                $display("FAIL stall t=%0t got=%b exp=%b", $time, stall, e[2]);
            end
            if (err_ovf !== e[1]) begin
                errors++;
                $display("FAIL err_ovf t=%0t got=%b exp=%b", $time, err_ovf, e[1]);
            end
            if (err_unf !== e[0]) begin
                errors++;
                $display("FAIL err_unf t=%0t got=%b exp=%b", $time, err_unf, e[0]);
            end
        end else if (done) begin
            checks++;
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        model_clear();
        rst = 1'b1; WB_Write = 0; WB_Addr = 0; WB_Data = 0;
        rs_addr = 0; rt_addr = 0; rs_use = 0; rt_use = 0;
        iss_valid = 0; iss_we = 0; iss_addr = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state and a first write
        cyc(0, 0, 0, 0, 5, 0, 1, 1, 0, 0, 0);
        cyc(0, 1, 5, 32'hDEADBEEF, 5, 0, 1, 1, 0, 0, 0);
        idle(5, 0);

        // $0 is never written nor counted
        cyc(0, 1, 0, 32'h12345678, 0, 0, 1, 1, 0, 0, 0);
        idle(0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0);
        idle(0, 0);

        // Write-through
        cyc(0, 1, 7, 32'h11, 0, 7, 0, 0, 0, 0, 0);
        cyc(0, 1, 7, 32'h22, 0, 7, 0, 0, 0, 0, 0);
        idle(0, 7);

        // Underflow on a fresh scoreboard
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 4, 32'h44, 4, 0, 1, 0, 0, 0, 0);
        idle(4, 0);

        // RAW stall and release
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 9);
        repeat (3) idle(9, 0);
        cyc(0, 1, 9, 32'hA5, 9, 0, 1, 0, 0, 0, 0);
        idle(9, 0);

        // Saturation, overflow, simultaneous issue/retire, drain
        repeat (3) cyc(0, 0, 0, 0, 0, 3, 0, 1, 1, 1, 3);
        cyc(0, 0, 0, 0, 0, 3, 0, 1, 1, 1, 3);
        cyc(0, 1, 3, 32'h33, 0, 3, 0, 1, 1, 1, 3);
        cyc(0, 1, 3, 32'h31, 0, 3, 0, 1, 0, 0, 0);
        cyc(0, 1, 3, 32'h32, 0, 3, 0, 1, 0, 0, 0);
        cyc(0, 1, 3, 32'h3F, 0, 3, 0, 1, 0, 0, 0);
        idle(0, 3);

        // Mid-operation reset discards pending state and data
        cyc(0, 1, 6, 32'h66, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6);
        idle(6, 6);
        cyc(1, 0, 0, 0, 6, 6, 1, 1, 0, 0, 0);
        idle(6, 6);

        // Randomized traffic over a small register window to force collisions
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 7)));
        end

        idle(0, 0);
        done = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL timeout t=%0t got=running exp=finished", $time);
        $fatal(1, "timeout");
    end

endmodule
